// File: rtl/hyper_target.sv
// hyper_target: HyperBus-style memory target on a DDR byte-pair interface.
// Optional CR0 register space is built when HYPER_TARGET_REGSPACE_EN is defined.
module hyper_target #(
  parameter int ADDR_W     = 16,
  parameter int LATENCY    = 6,
  parameter int DOUBLE_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              csn,
  input  logic              ck_active,
  input  logic [7:0]        dq_qa,
  input  logic [7:0]        dq_qb,
  input  logic              rwds_qa,
  input  logic              rwds_qb,
  output logic [7:0]        dq_da,
  output logic [7:0]        dq_db,
  output logic              rwds_da,
  output logic              rwds_db,
  output logic              dq_oe,
  output logic              rwds_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CA    = 3'd1,
    S_LAT   = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_REGWR = 3'd5
  } state_e;

  localparam int LAT_TOT = (DOUBLE_LAT != 0) ? 2 * LATENCY : LATENCY;
  localparam int LAT_W   = (LAT_TOT > 1) ? $clog2(LAT_TOT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LAT_TOT - 1);
  localparam logic DBL = (DOUBLE_LAT != 0);
`ifdef HYPER_TARGET_REGSPACE_EN
  localparam logic [ADDR_W-1:0] CR0_ADDR = ADDR_W'(32'h0000_0800);
`endif

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic [31:0]       ca_q, ca_d;
  logic [1:0]        ca_cnt_q, ca_cnt_d;
  logic              is_rd_q, is_rd_d;
  logic              is_reg_q, is_reg_d;
  logic              linear_q, linear_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [15:0]       skid_q, skid_d;
  logic              skid_vld_q, skid_vld_d;
  logic              reg_done_q, reg_done_d;
`ifdef HYPER_TARGET_REGSPACE_EN
  logic [15:0]       cr0_q, cr0_d;
`endif

  logic [7:0]        dq_da_q, dq_da_d, dq_db_q, dq_db_d;
  logic              rwds_da_q, rwds_da_d, rwds_db_q, rwds_db_d;
  logic              dq_oe_q, dq_oe_d, rwds_oe_q, rwds_oe_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;

  logic [15:0]       word;
  logic [47:0]       ca_full;
  logic [ADDR_W-1:0] start_addr;
  logic [15:0]       reg_rdata;
  logic [15:0]       rd_word;
  logic              fetch;
  logic              unused_ca;

  assign word       = {dq_qa, dq_qb};
  assign ca_full    = {ca_q, word};
  assign start_addr = ADDR_W'({ca_full[44:16], ca_full[2:0]});
  assign unused_ca  = ^ca_full[15:3];

  // Wrapped bursts only step the low nibble; the 16-word group stays fixed.
  function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] a, input logic lin);
    logic [ADDR_W-1:0] r;
    r = a + ADDR_W'(1);
    if (!lin) r = {a[ADDR_W-1:4], r[3:0]};
    return r;
  endfunction

  always_comb begin
    reg_rdata = 16'h0000;
`ifdef HYPER_TARGET_REGSPACE_EN
    if (mem_addr_q == CR0_ADDR) reg_rdata = cr0_q;
`endif
  end

  // The word returning this clk belongs to the fetch issued on the previous clk.
  assign rd_word = is_reg_q ? reg_rdata : mem_rdata;

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | csn;
    ca_d        = ca_q;
    ca_cnt_d    = ca_cnt_q;
    is_rd_d     = is_rd_q;
    is_reg_d    = is_reg_q;
    linear_d    = linear_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    rd_pend_d   = 1'b0;
    skid_d      = skid_q;
    skid_vld_d  = skid_vld_q;
    reg_done_d  = reg_done_q;
`ifdef HYPER_TARGET_REGSPACE_EN
    cr0_d       = cr0_q;
`endif
    dq_da_d     = dq_da_q;
    dq_db_d     = dq_db_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    fetch       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!csn && armed_q) begin
          state_d  = S_CA;
          ca_cnt_d = 2'd0;
        end
      end
      S_CA: begin
        if (ck_active) begin
          ca_d     = ca_full[31:0];
          ca_cnt_d = ca_cnt_q + 2'd1;
          if (ca_cnt_q == 2'd2) begin
            is_rd_d    = ca_full[47];
            is_reg_d   = ca_full[46];
            linear_d   = ca_full[45];
            addr_d     = start_addr;
            lat_cnt_d  = LAT_INIT;
            reg_done_d = 1'b0;
            skid_vld_d = 1'b0;
            state_d    = (ca_full[46] && !ca_full[47]) ? S_REGWR : S_LAT;
          end
        end
      end
      S_LAT: begin
        if (ck_active) begin
          if (lat_cnt_q == '0) begin
            state_d = is_rd_q ? S_READ : S_WRITE;
            fetch   = is_rd_q;
          end else begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (ck_active) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = word;
          mem_be_d    = {~rwds_qa, ~rwds_qb};
          addr_d      = adv(addr_q, linear_q);
        end
      end
      S_READ: begin
        if (ck_active) begin
          fetch = 1'b1;
          if (skid_vld_q) begin
            {dq_da_d, dq_db_d} = skid_q;
            skid_vld_d         = 1'b0;
          end else if (rd_pend_q) begin
            {dq_da_d, dq_db_d} = rd_word;
          end
        end else if (rd_pend_q) begin
          skid_d     = rd_word;
          skid_vld_d = 1'b1;
        end
      end
      S_REGWR: begin
        if (ck_active && !reg_done_q) begin
          reg_done_d = 1'b1;
`ifdef HYPER_TARGET_REGSPACE_EN
          if (addr_q == CR0_ADDR) cr0_d = word;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fetch) begin
      rd_pend_d  = 1'b1;
      mem_re_d   = !is_reg_q;
      mem_addr_d = addr_q;
      addr_d     = adv(addr_q, linear_q);
    end

    if (csn) state_d = S_IDLE;

    // Bus-facing outputs follow the state being entered so they stay registered.
    dq_oe_d   = (state_d == S_READ);
    rwds_oe_d = (state_d == S_READ) || (state_d == S_CA);
    rwds_da_d = (state_d == S_READ) || ((state_d == S_CA) && DBL);
    rwds_db_d = (state_d == S_CA) && DBL;
    if (state_d != S_READ) begin
      dq_da_d = 8'h00;
      dq_db_d = 8'h00;
    end
    if (state_d == S_IDLE) begin
      mem_re_d  = 1'b0;
      mem_we_d  = 1'b0;
      rd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      ca_q        <= '0;
      ca_cnt_q    <= '0;
      is_rd_q     <= 1'b0;
      is_reg_q    <= 1'b0;
      linear_q    <= 1'b0;
      lat_cnt_q   <= '0;
      addr_q      <= '0;
      rd_pend_q   <= 1'b0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      reg_done_q  <= 1'b0;
`ifdef HYPER_TARGET_REGSPACE_EN
      cr0_q       <= 16'h8F1F;
`endif
      dq_da_q     <= '0;
      dq_db_q     <= '0;
      rwds_da_q   <= 1'b0;
      rwds_db_q   <= 1'b0;
      dq_oe_q     <= 1'b0;
      rwds_oe_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      ca_q        <= ca_d;
      ca_cnt_q    <= ca_cnt_d;
      is_rd_q     <= is_rd_d;
      is_reg_q    <= is_reg_d;
      linear_q    <= linear_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      rd_pend_q   <= rd_pend_d;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
      reg_done_q  <= reg_done_d;
`ifdef HYPER_TARGET_REGSPACE_EN
      cr0_q       <= cr0_d;
`endif
      dq_da_q     <= dq_da_d;
      dq_db_q     <= dq_db_d;
      rwds_da_q   <= rwds_da_d;
      rwds_db_q   <= rwds_db_d;
      dq_oe_q     <= dq_oe_d;
      rwds_oe_q   <= rwds_oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign dq_da       = dq_da_q;
  assign dq_db       = dq_db_q;
  assign rwds_da     = rwds_da_q;
  assign rwds_db     = rwds_db_q;
  assign dq_oe       = dq_oe_q;
  assign rwds_oe     = rwds_oe_q;
  assign mem_addr    = mem_addr_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hyper_target.sv
// tb_hyper_target: directed and randomized bursts against a word-level memory model.
// Expected register contents depend on HYPER_TARGET_REGSPACE_EN.
module tb_hyper_target;
  localparam int ADDR_W     = 16;
  localparam int LATENCY    = 6;
  localparam int DOUBLE_LAT = 1;
  localparam int LAT_CYC    = (DOUBLE_LAT != 0) ? LATENCY * 2 : LATENCY;

  logic        clk = 1'b0;
  logic        reset_n, csn, ck_active;
  logic [7:0]  dq_qa, dq_qb, dq_da, dq_db;
  logic        rwds_qa, rwds_qb, rwds_da, rwds_db, dq_oe, rwds_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic        mem_re, mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  hyper_target #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .DOUBLE_LAT(DOUBLE_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .csn(csn), .ck_active(ck_active),
    .dq_qa(dq_qa), .dq_qb(dq_qb), .rwds_qa(rwds_qa), .rwds_qb(rwds_qb),
    .dq_da(dq_da), .dq_db(dq_db), .rwds_da(rwds_da), .rwds_db(rwds_db),
    .dq_oe(dq_oe), .rwds_oe(rwds_oe), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_arr [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] exp_q [$];
  logic [15:0] wbuf [0:15];
  logic [1:0]  mbuf [0:15];
  logic [15:0] cr0_m;
  int checks = 0;
  int failures = 0;

  // Memory: data for a mem_re cycle is sampled by the target on the following edge.
  assign mem_rdata = mem_re ? mem_arr[mem_addr] : 16'hDEAD;
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_be[1]) mem_arr[mem_addr][15:8] <= mem_wdata[15:8];
      if (mem_be[0]) mem_arr[mem_addr][7:0]  <= mem_wdata[7:0];
    end
  end

  function automatic int next_addr(input int a, input bit lin);
    if (lin) return (a + 1) % 65536;
    return (a / 16) * 16 + ((a + 1) % 16);
  endfunction

  function automatic logic [47:0] make_ca(input bit rd, input bit rg, input bit lin, input int addr);
    logic [47:0] ca;
    ca = '0;
    ca[47] = rd;
    ca[46] = rg;
    ca[45] = lin;
    ca[44:16] = 29'(addr / 8);
    ca[2:0] = 3'(addr % 8);
    return ca;
  endfunction

  function automatic logic [15:0] reg_model(input int a);
`ifdef HYPER_TARGET_REGSPACE_EN
    return (a == 16'h0800) ? cr0_m : 16'h0000;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic send_ca(input logic [47:0] ca);
    logic [47:0] sh;
    logic [1:0] rw;
    rw = (DOUBLE_LAT != 0) ? 2'b11 : 2'b00;
    csn = 1'b0;
    ck_active = 1'b0;
    tick();
    chk("ca_rwds_oe", rwds_oe, 1);
    chk("ca_rwds", {rwds_da, rwds_db}, rw);
    chk("ca_dq_oe", dq_oe, 0);
    sh = ca;
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ck_active = 1'b0;
        tick();
      end
      ck_active = 1'b1;
      {dq_qa, dq_qb} = sh[47:32];
      sh = sh << 16;
      tick();
    end
    ck_active = 1'b0;
  endtask

  task automatic lat_phase(input bit mem_rd, input int start);
    for (int i = 0; i < LAT_CYC; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ck_active = 1'b0;
        tick();
      end
      ck_active = 1'b1;
      tick();
      if (i == 0) chk("lat_no_early_re", mem_re, 0);
      if (i == LAT_CYC - 1) begin
        chk("lat_last_re", mem_re, mem_rd);
        if (mem_rd) chk("lat_last_addr", mem_addr, start);
        chk("lat_no_we", mem_we, 0);
      end
    end
    ck_active = 1'b0;
  endtask

  task automatic end_txn();
    csn = 1'b1;
    ck_active = 1'b0;
    tick();
    chk("end_oe", {dq_oe, rwds_oe}, 0);
    chk("end_strobe", {mem_re, mem_we}, 0);
  endtask

  task automatic do_write(input bit lin, input int start, input int n, input int maxp);
    int a;
    logic [1:0] be_exp;
    a = start;
    send_ca(make_ca(0, 0, lin, start));
    lat_phase(0, start);
    for (int i = 0; i < n; i++) begin
      for (int p = $urandom_range(0, maxp); p > 0; p--) begin
        ck_active = 1'b0;
        tick();
        chk("wr_pause_we", mem_we, 0);
      end
      ck_active = 1'b1;
      {dq_qa, dq_qb} = wbuf[i];
      {rwds_qa, rwds_qb} = mbuf[i];
      tick();
      be_exp = ~mbuf[i];
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, a);
      chk("wr_data", mem_wdata, wbuf[i]);
      chk("wr_be", mem_be, be_exp);
      if (!mbuf[i][1]) ref_mem[a][15:8] = wbuf[i][15:8];
      if (!mbuf[i][0]) ref_mem[a][7:0] = wbuf[i][7:0];
      a = next_addr(a, lin);
    end
    rwds_qa = 1'b0;
    rwds_qb = 1'b0;
    end_txn();
  endtask

  task automatic do_read(input bit lin, input bit rg, input int start, input int n,
                         input int maxp, input int pause_at);
    int a;
    int np;
    logic [15:0] shown;
    logic [15:0] got;
    a = start;
    shown = 16'h0000;
    send_ca(make_ca(1, rg, lin, start));
    lat_phase(!rg, start);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(rg ? reg_model(a) : ref_mem[a]);
      np = (i == pause_at) ? 3 : $urandom_range(0, maxp);
      for (int p = 0; p < np; p++) begin
        ck_active = 1'b0;
        tick();
        chk("rd_hold", {dq_da, dq_db}, shown);
        chk("rd_pause_re", mem_re, 0);
      end
      ck_active = 1'b1;
      tick();
      got = {dq_da, dq_db};
      shown = exp_q.pop_front();
      chk("rd_data", got, shown);
      chk("rd_rwds", {rwds_da, rwds_db}, 2'b10);
      chk("rd_oe", {dq_oe, rwds_oe}, 2'b11);
      a = next_addr(a, lin);
      chk("rd_next_re", mem_re, !rg);
      if (!rg) chk("rd_next_addr", mem_addr, a);
    end
    end_txn();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 16'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    cr0_m = 16'h8F1F;
    reset_n = 1'b0; csn = 1'b1; ck_active = 1'b0;
    dq_qa = 8'h00; dq_qb = 8'h00; rwds_qa = 1'b0; rwds_qb = 1'b0;
    repeat (3) tick();
    chk("rst_dq", {dq_da, dq_db}, 0);
    chk("rst_rwds", {rwds_da, rwds_db}, 0);
    chk("rst_oe", {dq_oe, rwds_oe}, 0);
    chk("rst_strobe", {mem_re, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    reset_n = 1'b1;
    tick();

    do_read(1, 1, 16'h0800, 1, 0, -1);

    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD; mbuf[0] = 2'b00; mbuf[1] = 2'b00;
    do_write(1, 4, 2, 0);

    wbuf[0] = 16'h55AA; mbuf[0] = 2'b10;
    do_write(1, 16'h20, 1, 0);
    do_read(1, 0, 16'h20, 1, 0, -1);

    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 16'($urandom);
      mbuf[i] = 2'b00;
    end
    do_write(0, 16'h0E, 4, 0);
    do_read(0, 0, 16'h0E, 4, 0, -1);
    do_read(1, 0, 16'h04, 4, 0, 2);

    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 16'($urandom);
      mbuf[i] = 2'b00;
    end
    do_write(1, 16'hFFFE, 4, 1);
    do_read(1, 0, 16'hFFFE, 4, 1, -1);

    for (int it = 0; it < 10; it++) begin
      int st, n;
      bit lin;
      lin = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 65535);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        wbuf[i] = 16'($urandom);
        mbuf[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      end
      do_write(lin, st, n, 2);
      do_read(lin, 0, st, n, 2, -1);
    end

    // Abort mid-write: the word presented with csn high must not be written.
    send_ca(make_ca(0, 0, 1, 16'h0100));
    lat_phase(0, 16'h0100);
    ck_active = 1'b1; {dq_qa, dq_qb} = 16'hC0DE; tick();
    chk("abort_first_we", mem_we, 1);
    ref_mem[16'h0100] = 16'hC0DE;
    csn = 1'b1; {dq_qa, dq_qb} = 16'hBAD0; tick();
    chk("abort_we", mem_we, 0);
    chk("abort_oe", {dq_oe, rwds_oe}, 0);
    tick();
    chk("abort_we_after", mem_we, 0);
    ck_active = 1'b0;
    tick();
    do_read(1, 0, 16'h0100, 2, 0, -1);

    send_ca(48'h6000_0100_0000);
    ck_active = 1'b1; {dq_qa, dq_qb} = 16'h8F17; tick();
    chk("regwr_no_we", mem_we, 0);
`ifdef HYPER_TARGET_REGSPACE_EN
    cr0_m = 16'h8F17;
`endif
    {dq_qa, dq_qb} = 16'h1111; tick();
    end_txn();
    do_read(1, 1, 16'h0800, 1, 0, -1);

    // Reset mid-read, then confirm no transaction starts until csn is seen high.
    send_ca(make_ca(1, 0, 1, 16'h0200));
    lat_phase(1, 16'h0200);
    ck_active = 1'b1; tick();
    reset_n = 1'b0; tick();
    chk("rst_mid_oe", {dq_oe, rwds_oe}, 0);
    chk("rst_mid_strobe", {mem_re, mem_we}, 0);
    chk("rst_mid_dq", {dq_da, dq_db}, 0);
    chk("rst_mid_addr", mem_addr, 0);
    cr0_m = 16'h8F1F;
    reset_n = 1'b1; csn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ck_active = 1'b1; {dq_qa, dq_qb} = 16'h8000; tick();
      chk("unarmed_rwds_oe", rwds_oe, 0);
    end
    ck_active = 1'b0; csn = 1'b1; tick();
    do_read(1, 1, 16'h0800, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
